axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem
//   AXI3-style slave backed by an internal MEM_WORDS x DATA_W array.
//   The write path (AW -> W -> B) and the read path (AR queue -> latency
//   wait -> R beats) are independent state machines sharing only the array.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   i_aw* / o_awready      write command (addr, id, len = beats-1, burst)
//   i_w*  / o_wready       write data beats, byte strobes, wlast (i_wid unused)
//   o_b*  / i_bready       write response (captured id, OKAY/SLVERR)
//   i_ar* / o_arready      read command, buffered in an AR_DEPTH queue
//   o_r*  / i_rready       read data beats with id, resp, last
//   o_err_wlast            one-cycle pulse when wlast disagrees with awlen
module axi_slave_mem #(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024,
  parameter int AR_DEPTH  = 4,
  parameter int RD_LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_awaddr,
  input  logic [ID_W-1:0]   i_awid,
  input  logic [3:0]        i_awlen,
  input  logic [1:0]        i_awburst,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ID_W-1:0]   i_wid,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic              i_wlast,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [ID_W-1:0]   o_bid,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  input  logic [31:0]       i_araddr,
  input  logic [ID_W-1:0]   i_arid,
  input  logic [3:0]        i_arlen,
  input  logic [1:0]        i_arburst,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ID_W-1:0]   o_rid,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_err_wlast
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int AQ_W  = $clog2(AR_DEPTH);
  // R_WAIT lasts RD_LAT-1 cycles; the counter runs down to zero inclusive.
  localparam logic [3:0] WAIT_INIT = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;

  typedef struct packed {
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic [3:0]      len;
    logic [1:0]      burst;
  } ar_cmd_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  function automatic logic [IDX_W-1:0] widx(input logic [31:0] a);
    return a[IDX_W+OFF_W-1:OFF_W];
  endfunction

  function automatic logic oor(input logic [31:0] a);
    return (a >> (IDX_W + OFF_W)) != 32'd0;
  endfunction

  // WRAP keeps the upper address bits and wraps the offset inside the
  // (len+1)*BYTES window; non power-of-two lengths fall back to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [3:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] inc;
    logic [31:0] win;
    logic        wrap_ok;
    inc     = a + 32'(BYTES);
    win     = (32'(len) + 32'd1) * 32'(BYTES) - 32'd1;
    wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    case (burst)
      2'b00:   return a;
      2'b10:   return wrap_ok ? ((a & ~win) | (inc & win)) : inc;
      default: return inc;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- write
  wstate_t         w_state, w_next;
  logic [31:0]     aw_addr;
  logic [ID_W-1:0] aw_id;
  logic [3:0]      aw_len;
  logic [1:0]      aw_burst;
  logic [3:0]      w_cnt;
  logic            w_err;
  logic            aw_fire, w_fire, w_last_exp;

  assign aw_fire    = i_awvalid && (w_state == W_IDLE);
  assign w_fire     = i_wvalid && (w_state == W_DATA);
  assign w_last_exp = (w_cnt == aw_len);

  always_ff @(posedge clk or posedge rst)
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (i_awvalid)              w_next = W_DATA;
      W_DATA:  if (i_wvalid && w_last_exp) w_next = W_RESP;
      W_RESP:  if (i_bready)               w_next = W_IDLE;
      default:                             w_next = W_IDLE;
    endcase
  end

  always_comb begin
    o_awready   = (w_state == W_IDLE);
    o_wready    = (w_state == W_DATA);
    o_bvalid    = (w_state == W_RESP);
    o_bid       = aw_id;
    o_bresp     = (o_bvalid && w_err) ? 2'b10 : 2'b00;
    o_err_wlast = w_fire && (i_wlast != w_last_exp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_addr  <= '0;
      aw_id    <= '0;
      aw_len   <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else if (aw_fire) begin
      aw_addr  <= i_awaddr;
      aw_id    <= i_awid;
      aw_len   <= i_awlen;
      aw_burst <= i_awburst;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else if (w_fire) begin
      aw_addr <= next_addr(aw_addr, aw_len, aw_burst);
      w_cnt   <= w_cnt + 4'd1;
      if (oor(aw_addr) || (i_wlast != w_last_exp)) w_err <= 1'b1;
    end
  end

  // Array is never reset so contents survive a mid-burst reset.
  always_ff @(posedge clk)
    if (w_fire && !oor(aw_addr))
      for (int b = 0; b < BYTES; b++)
        if (i_wstrb[b]) mem[widx(aw_addr)][b*8 +: 8] <= i_wdata[b*8 +: 8];

  logic unused_wid;
  assign unused_wid = ^i_wid;

  // --------------------------------------------------------------- AR queue
  ar_cmd_t          aq [AR_DEPTH];
  logic [AQ_W-1:0]  aq_wp, aq_rp;
  logic [AQ_W:0]    aq_cnt;
  logic             aq_empty, ar_push, ar_pop;
  ar_cmd_t          aq_head;

  assign aq_empty  = (aq_cnt == '0);
  assign o_arready = (aq_cnt != (AQ_W+1)'(AR_DEPTH));
  assign ar_push   = i_arvalid && o_arready;
  assign aq_head   = aq[aq_rp];

  always_ff @(posedge clk)
    if (ar_push) aq[aq_wp] <= '{i_araddr, i_arid, i_arlen, i_arburst};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_wp  <= '0;
      aq_rp  <= '0;
      aq_cnt <= '0;
    end else begin
      if (ar_push) aq_wp <= aq_wp + AQ_W'(1);
      if (ar_pop)  aq_rp <= aq_rp + AQ_W'(1);
      case ({ar_push, ar_pop})
        2'b10:   aq_cnt <= aq_cnt + (AQ_W+1)'(1);
        2'b01:   aq_cnt <= aq_cnt - (AQ_W+1)'(1);
        default: aq_cnt <= aq_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------------ read
  rstate_t         r_state, r_next;
  logic [31:0]     r_addr, r_nxt, r_ld_addr;
  logic [ID_W-1:0] r_id;
  logic [3:0]      r_len, r_beat, r_wait;
  logic [1:0]      r_burst;
  logic            r_fire, r_at_last, r_ld_first, r_ld_next;

  assign r_fire    = (r_state == R_DATA) && i_rready;
  assign r_at_last = (r_beat == r_len);
  assign r_nxt     = next_addr(r_addr, r_len, r_burst);
  // The beat register is loaded one cycle before it is shown: at the end of
  // the latency wait (or at pop when RD_LAT is 1), and on each non-last
  // handshake so the following beat appears without a bubble.
  assign r_ld_first = ((r_state == R_WAIT) && (r_wait == 4'd0)) ||
                      ((r_state == R_IDLE) && !aq_empty && (RD_LAT == 1));
  assign r_ld_next  = r_fire && !r_at_last;
  assign r_ld_addr  = r_ld_next ? r_nxt :
                      (r_state == R_IDLE) ? aq_head.addr : r_addr;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (!aq_empty)            r_next = (RD_LAT == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_wait == 4'd0)       r_next = R_DATA;
      R_DATA:  if (i_rready && r_at_last) r_next = R_IDLE;
      default:                           r_next = R_IDLE;
    endcase
  end

  always_comb begin
    o_rvalid = (r_state == R_DATA);
    o_rlast  = o_rvalid && r_at_last;
    o_rid    = r_id;
    ar_pop   = (r_state == R_IDLE) && !aq_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
      o_rdata <= '0;
      o_rresp <= 2'b00;
    end else begin
      if (ar_pop) begin
        r_addr  <= aq_head.addr;
        r_id    <= aq_head.id;
        r_len   <= aq_head.len;
        r_burst <= aq_head.burst;
        r_beat  <= '0;
        r_wait  <= WAIT_INIT;
      end else if ((r_state == R_WAIT) && (r_wait != 4'd0)) begin
        r_wait <= r_wait - 4'd1;
      end
      if (r_ld_next) begin
        r_addr <= r_nxt;
        r_beat <= r_beat + 4'd1;
      end
      // Non-blocking read of mem returns pre-write data on a same-cycle write.
      if (r_ld_first || r_ld_next) begin
        o_rdata <= oor(r_ld_addr) ? '0 : mem[widx(r_ld_addr)];
        o_rresp <= oor(r_ld_addr) ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: directed stimulus pushes expected
// B and R responses into queues; monitors pop and compare on handshakes.
module tb_axi_slave_mem;
  localparam int DATA_W = 32, ID_W = 4, MEM_WORDS = 1024, AR_DEPTH = 4, RD_LAT = 3;
  localparam int TMO = 200;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] i_awaddr = '0, i_araddr = '0, i_wdata = '0;
  logic [3:0]  i_awid = '0, i_awlen = '0, i_wid = '0, i_wstrb = '0, i_arid = '0, i_arlen = '0;
  logic [1:0]  i_awburst = '0, i_arburst = '0;
  logic i_awvalid = 0, i_wlast = 0, i_wvalid = 0, i_bready = 1, i_arvalid = 0, i_rready = 1;
  logic o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid, o_err_wlast;
  logic [3:0]  o_bid, o_rid;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata;

  axi_slave_mem #(.DATA_W(DATA_W), .ID_W(ID_W), .MEM_WORDS(MEM_WORDS),
                  .AR_DEPTH(AR_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_awaddr(i_awaddr), .i_awid(i_awid), .i_awlen(i_awlen), .i_awburst(i_awburst),
    .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wid(i_wid), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arid(i_arid), .i_arlen(i_arlen), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_err_wlast(o_err_wlast));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] id; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re;
  bexp_t be;
  logic [31:0] wbuf [16];
  int checks = 0, errors = 0, err_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++; errors++;
    $display("FAIL %s: got timeout expected event within %0d cycles", name, TMO);
  endtask

  // Monitors sample on the falling edge, between driver updates.
  always @(negedge clk) if (!rst) begin
    if (o_rvalid && i_rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_extra: got beat rid=%0h data=%0h expected none", o_rid, o_rdata);
      end else begin
        re = rq.pop_front();
        chk("rdata", o_rdata, re.data);
        chk("rid",   o_rid,   re.id);
        chk("rresp", o_rresp, re.resp);
        chk("rlast", o_rlast, re.last);
      end
    end
    if (o_bvalid && i_bready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra: got bid=%0h expected none", o_bid);
      end else begin
        be = bq.pop_front();
        chk("bid",   o_bid,   be.id);
        chk("bresp", o_bresp, be.resp);
      end
    end
    if (o_err_wlast) err_pulses++;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic exp_r(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp, input logic last);
    rq.push_back('{d, id, resp, last});
  endtask

  task automatic exp_b(input logic [3:0] id, input logic [1:0] resp);
    bq.push_back('{id, resp});
  endtask

  // Beat i takes wbuf[i]; wlast follows bit i of lmask.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input logic [15:0] lmask);
    int n;
    i_awaddr = addr; i_awid = id; i_awlen = len; i_awburst = burst; i_awvalid = 1;
    n = 0;
    while (!o_awready && n < TMO) begin tick(); n++; end
    if (n >= TMO) tmo("aw_handshake");
    tick(); i_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      i_wdata = wbuf[i]; i_wstrb = strb; i_wlast = lmask[i]; i_wvalid = 1;
      n = 0;
      while (!o_wready && n < TMO) begin tick(); n++; end
      if (n >= TMO) tmo("w_handshake");
      tick();
    end
    i_wvalid = 0; i_wlast = 0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                       input logic [1:0] burst);
    int n;
    i_araddr = addr; i_arid = id; i_arlen = len; i_arburst = burst; i_arvalid = 1;
    n = 0;
    while (!o_arready && n < TMO) begin tick(); n++; end
    if (n >= TMO) tmo("ar_handshake");
    tick(); i_arvalid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < TMO) begin tick(); n++; end
    if (n >= TMO) tmo("drain");
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_ctrl", {o_bvalid, o_rvalid, o_rlast, o_err_wlast, o_bresp, o_rresp, o_bid, o_rid}, 0);
    chk("rst_rdata", o_rdata, 0);
    rst = 0;
    chk("awready_first", o_awready, 1);
    chk("arready_first", o_arready, 1);

    // INCR 4-beat write then read back, with first-beat latency.
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    exp_b(4'h5, 2'b00);
    do_write(32'h100, 4'h5, 4'd3, 2'b01, 4'hF, 16'h0008);
    drain();
    chk("no_err_wlast", err_pulses, 0);
    exp_r(32'h11111111, 4'h6, 2'b00, 0); exp_r(32'h22222222, 4'h6, 2'b00, 0);
    exp_r(32'h33333333, 4'h6, 2'b00, 0); exp_r(32'h44444444, 4'h6, 2'b00, 1);
    do_ar(32'h100, 4'h6, 4'd3, 2'b01);
    // Counted in clock edges from the AR handshake edge: pop happens in the
    // first cycle after it, so rvalid shows RD_LAT edges later.
    n = 0;
    do begin tick(); n++; end while (!o_rvalid && n < TMO);
    chk("rd_latency", n, RD_LAT);
    drain();

    // Partial strobes: lanes 0 and 2 take new bytes, 1 and 3 keep 0x22.
    wbuf[0] = 32'hAABBCCDD;
    exp_b(4'h2, 2'b00);
    do_write(32'h104, 4'h2, 4'd0, 2'b01, 4'b0101, 16'h0001);
    exp_r(32'h22BB22DD, 4'h3, 2'b00, 1);
    do_ar(32'h104, 4'h3, 4'd0, 2'b01);
    drain();

    // Fill 0x10..0x20, then WRAP len 3 and WRAP len 2 (acts as INCR).
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3; wbuf[4] = 32'hA4;
    exp_b(4'h4, 2'b00);
    do_write(32'h10, 4'h4, 4'd4, 2'b01, 4'hF, 16'h0010);
    exp_r(32'hA2, 4'h7, 2'b00, 0); exp_r(32'hA3, 4'h7, 2'b00, 0);
    exp_r(32'hA0, 4'h7, 2'b00, 0); exp_r(32'hA1, 4'h7, 2'b00, 1);
    do_ar(32'h18, 4'h7, 4'd3, 2'b10);
    exp_r(32'hA2, 4'h8, 2'b00, 0); exp_r(32'hA3, 4'h8, 2'b00, 0); exp_r(32'hA4, 4'h8, 2'b00, 1);
    do_ar(32'h18, 4'h8, 4'd2, 2'b10);
    drain();

    // FIXED: all beats land on one word, last one wins.
    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2;
    exp_b(4'h1, 2'b00);
    do_write(32'h200, 4'h1, 4'd2, 2'b00, 4'hF, 16'h0004);
    exp_r(32'hB2, 4'h1, 2'b00, 0); exp_r(32'hB2, 4'h1, 2'b00, 1);
    do_ar(32'h200, 4'h1, 4'd1, 2'b00);
    drain();

    // AR_DEPTH+1 commands with rready low: the read engine holds the first,
    // the queue holds the remaining AR_DEPTH and then reports full.
    i_rready = 0;
    exp_r(32'h11111111, 4'h1, 2'b00, 1); exp_r(32'h22BB22DD, 4'h2, 2'b00, 1);
    exp_r(32'h33333333, 4'h3, 2'b00, 1); exp_r(32'h44444444, 4'h4, 2'b00, 1);
    exp_r(32'hA0, 4'h5, 2'b00, 1);
    do_ar(32'h100, 4'h1, 4'd0, 2'b01);
    do_ar(32'h104, 4'h2, 4'd0, 2'b01);
    do_ar(32'h108, 4'h3, 4'd0, 2'b01);
    do_ar(32'h10C, 4'h4, 4'd0, 2'b01);
    do_ar(32'h010, 4'h5, 4'd0, 2'b01);
    chk("arready_full", o_arready, 0);
    repeat (4) tick();
    chk("arready_held_low", o_arready, 0);
    chk("rvalid_stalled", o_rvalid, 1);
    chk("rdata_stalled", o_rdata, 32'h11111111);
    chk("rlast_stalled", o_rlast, 1);
    i_rready = 1;
    drain();
    chk("arready_drained", o_arready, 1);

    // Out-of-range write must not alias onto word 0.
    wbuf[0] = 32'h5A5A5A5A;
    exp_b(4'h3, 2'b00);
    do_write(32'h0, 4'h3, 4'd0, 2'b01, 4'hF, 16'h0001);
    wbuf[0] = 32'hDEADBEEF;
    exp_b(4'h4, 2'b10);
    do_write(32'h1000, 4'h4, 4'd0, 2'b01, 4'hF, 16'h0001);
    exp_r(32'h5A5A5A5A, 4'h5, 2'b00, 1);
    do_ar(32'h0, 4'h5, 4'd0, 2'b01);
    exp_r(32'h0, 4'h6, 2'b10, 1);
    do_ar(32'h1000, 4'h6, 4'd0, 2'b01);
    drain();
    // Burst that crosses the top of memory: first beat lands, second errors.
    wbuf[0] = 32'h77777777; wbuf[1] = 32'h88888888;
    exp_b(4'h7, 2'b10);
    do_write(32'hFFC, 4'h7, 4'd1, 2'b01, 4'hF, 16'h0002);
    exp_r(32'h77777777, 4'h8, 2'b00, 0); exp_r(32'h0, 4'h8, 2'b10, 1);
    do_ar(32'hFFC, 4'h8, 4'd1, 2'b01);
    drain();

    // Early wlast on beat 2 (correct wlast also on beat 4): one error pulse,
    // burst still four beats, SLVERR; response held while bready is low.
    err_pulses = 0;
    i_bready = 0;
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2; wbuf[3] = 32'hC3;
    exp_b(4'h9, 2'b10);
    do_write(32'h300, 4'h9, 4'd3, 2'b01, 4'hF, 16'b1010);
    repeat (2) tick();
    chk("bvalid_held", o_bvalid, 1);
    chk("bid_held", o_bid, 4'h9);
    chk("bresp_held", o_bresp, 2'b10);
    i_bready = 1;
    drain();
    chk("err_wlast_pulses", err_pulses, 1);
    exp_r(32'hC0, 4'hA, 2'b00, 0); exp_r(32'hC1, 4'hA, 2'b00, 0);
    exp_r(32'hC2, 4'hA, 2'b00, 0); exp_r(32'hC3, 4'hA, 2'b00, 1);
    do_ar(32'h300, 4'hA, 4'd3, 2'b01);
    drain();

    // Reset while beat 2 of a read is on the bus.
    exp_r(32'h11111111, 4'hB, 2'b00, 0);
    do_ar(32'h100, 4'hB, 4'd3, 2'b01);
    n = 0;
    while (!o_rvalid && n < TMO) begin tick(); n++; end
    if (n >= TMO) tmo("rvalid_before_rst");
    tick();
    chk("beat2_presented", {o_rvalid, o_rdata}, {1'b1, 32'h22BB22DD});
    rst = 1;
    tick();
    chk("rvalid_after_rst", o_rvalid, 0);
    rst = 0;
    chk("arready_after_rst", o_arready, 1);
    repeat (RD_LAT + 2) tick();
    chk("queue_empty_after_rst", o_rvalid, 0);
    exp_r(32'h22BB22DD, 4'hC, 2'b00, 1);
    do_ar(32'h104, 4'hC, 4'd0, 2'b01);
    exp_r(32'h44444444, 4'hD, 2'b00, 1);
    do_ar(32'h10C, 4'hD, 4'd0, 2'b01);
    drain();

    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
